// File: rtl/rp_bus_pkg.sv
// rp_bus_pkg: shared types and limits for the rp bench bus-slave models.
package rp_bus_pkg;

    localparam int LAT_MAX = 8;
    localparam int BUS_IW  = 6;
    localparam int BUS_DW  = 8;

    typedef struct packed {
        logic [BUS_IW-1:0] rid;
        logic [BUS_DW-1:0] rdt;
    } rp_bus_rsp_t;

endpackage

// File: rtl/rp_fifo.sv
// rp_fifo: generic synchronous show-ahead FIFO; head is visible
// the cycle after the push that fills an empty FIFO.
module rp_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = buf_q[rp_q];

    always_comb begin
        wp_d  = do_push ? inc(wp_q) : wp_q;
        rp_d  = do_pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) buf_q[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/rp_bus_mem.sv
// rp_bus_mem: bus-slave memory with masked writes, fixed read latency,
// tagged in-order read responses and bounded outstanding reads.
module rp_bus_mem
    import rp_bus_pkg::*;
#(
    parameter int    AW  = 13,
    parameter int    DW  = 8,
    parameter int    IW  = 6,
    parameter int    LAT = 1,
    parameter int    QD  = 4,
    parameter string FN  = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_vld,
    output logic                     req_rdy,
    input  logic                     req_wen,
    input  logic [AW-1:0]            req_adr,
    input  logic [DW-1:0]            req_wdt,
    input  logic [DW-1:0]            req_msk,
    input  logic [IW-1:0]            req_wid,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output logic [DW-1:0]            rsp_rdt,
    output logic [IW-1:0]            rsp_rid,
    output logic [$clog2(QD+1)-1:0]  out_cnt
);

    localparam int CW = $clog2(QD + 1);
    localparam int PW = IW + DW;

    if (LAT < 1 || LAT > LAT_MAX || QD < LAT + 1) begin : g_bad_cfg
        $error("rp_bus_mem: need 1 <= LAT <= LAT_MAX and QD >= LAT+1");
    end

    logic [DW-1:0] mem_q [2**AW];

    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc, rd_acc, wr_acc, pop;
    logic          in_v, ex_v;
    logic [PW-1:0] in_p, ex_p, head;
    logic          fifo_empty;
    logic          unused_full;

    // Requests in the reset cycle are dropped, not queued.
    assign req_rdy = (cnt_q < CW'(QD));
    assign acc     = req_vld & req_rdy & ~rst;
    assign rd_acc  = acc & ~req_wen;
    assign wr_acc  = acc & req_wen;

    assign in_v    = rd_acc;
    assign in_p    = {req_wid, mem_q[req_adr]};

    assign rsp_vld = ~fifo_empty;
    assign pop     = rsp_vld & rsp_rdy;
    assign {rsp_rid, rsp_rdt} = head;
    assign out_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[req_adr] <= (req_wdt & req_msk) | (mem_q[req_adr] & ~req_msk);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({rd_acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // The FIFO register is the last latency stage, so LAT-1 stages sit here.
    if (LAT == 1) begin : g_direct
        assign ex_v = in_v;
        assign ex_p = in_p;
    end else begin : g_dly
        logic [LAT-2:0] v_q;
        logic [PW-1:0]  p_q [LAT-1];

        always_ff @(posedge clk) begin
            if (rst) v_q <= '0;
            else     v_q <= (LAT-1)'({v_q, in_v});
        end

        always_ff @(posedge clk) begin
            p_q[0] <= in_p;
            for (int i = 1; i < LAT - 1; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end

        assign ex_v = v_q[LAT-2];
        assign ex_p = p_q[LAT-2];
    end

    rp_fifo #(
        .WIDTH (PW),
        .DEPTH (QD)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ex_v),
        .wdata_i (ex_p),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (unused_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_rp_bus_mem.sv
// tb_rp_bus_mem: drives a LAT=1 and a LAT=3 instance with shared stimulus
// and compares both against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_rp_bus_mem;

    localparam int QD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_vld, req_wen, rsp_rdy;
    logic [12:0] req_adr;
    logic [7:0]  req_wdt, req_msk;
    logic [5:0]  req_wid;
    logic        req_rdy [2];
    logic        rsp_vld [2];
    logic [7:0]  rsp_rdt [2];
    logic [5:0]  rsp_rid [2];
    logic [2:0]  out_cnt [2];

    rp_bus_mem #(.LAT(1), .QD(QD)) u_lat1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy[0]),
        .req_wen(req_wen), .req_adr(req_adr), .req_wdt(req_wdt),
        .req_msk(req_msk), .req_wid(req_wid), .rsp_vld(rsp_vld[0]),
        .rsp_rdy(rsp_rdy), .rsp_rdt(rsp_rdt[0]), .rsp_rid(rsp_rid[0]),
        .out_cnt(out_cnt[0])
    );

    rp_bus_mem #(.LAT(3), .QD(QD)) u_lat3 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy[1]),
        .req_wen(req_wen), .req_adr(req_adr), .req_wdt(req_wdt),
        .req_msk(req_msk), .req_wid(req_wid), .rsp_vld(rsp_vld[1]),
        .rsp_rdy(rsp_rdy), .rsp_rdt(rsp_rdt[1]), .rsp_rid(rsp_rid[1]),
        .out_cnt(out_cnt[1])
    );

    // Model: per instance a memory image and a queue of accepted reads,
    // each tagged with the edge number at which it was accepted.
    typedef struct packed {
        int         t;
        logic [5:0] rid;
        logic [7:0] rdt;
    } ent_t;

    ent_t       mq [2][$];
    logic [7:0] mm [2][8192];
    int         ecnt = 0;
    int         npass = 0;
    int         ntot = 0;
    logic       m_ok;
    ent_t       m_e;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic m_vld(input int d, input int e);
        return (mq[d].size() > 0) && (mq[d][0].t + lat(d) - 1 <= e);
    endfunction

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mq[d].delete();
            end else begin
                m_ok = (mq[d].size() < QD);
                if (rsp_rdy && m_vld(d, ecnt - 1)) void'(mq[d].pop_front());
                if (req_vld && m_ok) begin
                    if (req_wen) begin
                        mm[d][req_adr] = (req_wdt & req_msk) | (mm[d][req_adr] & ~req_msk);
                    end else begin
                        m_e.t   = ecnt;
                        m_e.rid = req_wid;
                        m_e.rdt = mm[d][req_adr];
                        mq[d].push_back(m_e);
                    end
                end
            end
        end
    end

    task automatic drv(input logic v, input logic w, input logic [12:0] a,
                       input logic [7:0] dt, input logic [7:0] m, input logic [5:0] id);
        req_vld = v;
        req_wen = w;
        req_adr = a;
        req_wdt = dt;
        req_msk = m;
        req_wid = id;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 13'h0, 8'h0, 8'h0, 6'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_rdy = 1'b0;
        idle();
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (rsp_vld[d] !== 1'b0) $display("FAIL reset_vld[%0d]: got %b want 0", d, rsp_vld[d]);
            else npass++;
            ntot++;
            if (out_cnt[d] !== 3'd0) $display("FAIL reset_cnt[%0d]: got %0d want 0", d, out_cnt[d]);
            else npass++;
            ntot++;
            if (req_rdy[d] !== 1'b1) $display("FAIL reset_rdy[%0d]: got %b want 1", d, req_rdy[d]);
            else npass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        rsp_rdy = 1'b0;
        drv(1'b1, 1'b1, 13'h010, 8'hA5, 8'hFF, 6'd0);
        cyc();
        drv(1'b1, 1'b0, 13'h010, 8'h00, 8'h00, 6'd3);
        cyc();
        idle();
        ntot++;
        if (rsp_vld[0] !== 1'b1 || rsp_rdt[0] !== 8'hA5 || rsp_rid[0] !== 6'd3)
            $display("FAIL basic_lat1: got vld=%b rdt=%h rid=%0d want 1 a5 3",
                     rsp_vld[0], rsp_rdt[0], rsp_rid[0]);
        else npass++;
        ntot++;
        if (rsp_vld[1] !== 1'b0) $display("FAIL basic_lat3_early: got vld=%b want 0", rsp_vld[1]);
        else npass++;
        ntot++;
        if (out_cnt[0] !== 3'd1 || out_cnt[1] !== 3'd1)
            $display("FAIL basic_cnt: got %0d/%0d want 1/1", out_cnt[0], out_cnt[1]);
        else npass++;
        cyc();
        cyc();
        ntot++;
        if (rsp_vld[1] !== 1'b1 || rsp_rdt[1] !== 8'hA5 || rsp_rid[1] !== 6'd3)
            $display("FAIL basic_lat3: got vld=%b rdt=%h rid=%0d want 1 a5 3",
                     rsp_vld[1], rsp_rdt[1], rsp_rid[1]);
        else npass++;
        ntot++;
        if (rsp_vld[0] !== 1'b1 || rsp_rdt[0] !== 8'hA5 || rsp_rid[0] !== 6'd3)
            $display("FAIL basic_hold: got vld=%b rdt=%h rid=%0d want 1 a5 3",
                     rsp_vld[0], rsp_rdt[0], rsp_rid[0]);
        else npass++;
        rsp_rdy = 1'b1;
        cyc();
        rsp_rdy = 1'b0;
        ntot++;
        if (rsp_vld[0] !== 1'b0 || rsp_vld[1] !== 1'b0 || out_cnt[0] !== 3'd0 || out_cnt[1] !== 3'd0)
            $display("FAIL basic_drain: got vld=%b/%b cnt=%0d/%0d want 0/0 0/0",
                     rsp_vld[0], rsp_vld[1], out_cnt[0], out_cnt[1]);
        else npass++;
    endtask

    task automatic test_masked();
        rsp_rdy = 1'b0;
        drv(1'b1, 1'b1, 13'h030, 8'hF0, 8'hFF, 6'd0);
        cyc();
        drv(1'b1, 1'b1, 13'h030, 8'h0F, 8'h3C, 6'd0);
        cyc();
        drv(1'b1, 1'b0, 13'h030, 8'h00, 8'h00, 6'd5);
        cyc();
        idle();
        ntot++;
        if (rsp_vld[0] !== 1'b1 || rsp_rdt[0] !== 8'hCC || rsp_rid[0] !== 6'd5)
            $display("FAIL masked_lat1: got vld=%b rdt=%h rid=%0d want 1 cc 5",
                     rsp_vld[0], rsp_rdt[0], rsp_rid[0]);
        else npass++;
        cyc();
        cyc();
        ntot++;
        if (rsp_vld[1] !== 1'b1 || rsp_rdt[1] !== 8'hCC)
            $display("FAIL masked_lat3: got vld=%b rdt=%h want 1 cc", rsp_vld[1], rsp_rdt[1]);
        else npass++;
        rsp_rdy = 1'b1;
        cyc();
        rsp_rdy = 1'b0;
    endtask

    task automatic test_raw();
        logic [7:0] dat;
        dat = 8'($urandom);
        rsp_rdy = 1'b1;
        drv(1'b1, 1'b1, 13'h020, dat, 8'hFF, 6'd0);
        cyc();
        drv(1'b1, 1'b0, 13'h020, 8'h00, 8'h00, 6'd7);
        cyc();
        idle();
        ntot++;
        if (rsp_vld[0] !== 1'b1 || rsp_rdt[0] !== dat || rsp_rid[0] !== 6'd7)
            $display("FAIL raw_lat1: got vld=%b rdt=%h rid=%0d want 1 %h 7",
                     rsp_vld[0], rsp_rdt[0], rsp_rid[0], dat);
        else npass++;
        cyc();
        cyc();
        ntot++;
        if (rsp_vld[1] !== 1'b1 || rsp_rdt[1] !== dat || rsp_rid[1] !== 6'd7)
            $display("FAIL raw_lat3: got vld=%b rdt=%h rid=%0d want 1 %h 7",
                     rsp_vld[1], rsp_rdt[1], rsp_rid[1], dat);
        else npass++;
        cyc();
        ntot++;
        if (out_cnt[0] !== 3'd0 || out_cnt[1] !== 3'd0)
            $display("FAIL raw_drain: got cnt=%0d/%0d want 0/0", out_cnt[0], out_cnt[1]);
        else npass++;
        rsp_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] dat [8];
        rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dat[i] = 8'($urandom);
            drv(1'b1, 1'b1, 13'(13'h100 + i), dat[i], 8'hFF, 6'd0);
            cyc();
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                ntot++;
                if (req_rdy[0] !== 1'b1 || req_rdy[1] !== 1'b1)
                    $display("FAIL b2b_rdy k=%0d: got %b/%b want 1/1", k, req_rdy[0], req_rdy[1]);
                else npass++;
                drv(1'b1, 1'b0, 13'(13'h100 + k), 8'h00, 8'h00, 6'(k));
            end else begin
                idle();
            end
            cyc();
            if (k >= 2 && k < 10) begin
                ntot++;
                if (rsp_vld[1] !== 1'b1 || rsp_rid[1] !== 6'(k - 2) || rsp_rdt[1] !== dat[k-2])
                    $display("FAIL b2b_rsp k=%0d: got vld=%b rid=%0d rdt=%h want 1 %0d %h",
                             k, rsp_vld[1], rsp_rid[1], rsp_rdt[1], k - 2, dat[k-2]);
                else npass++;
            end else begin
                ntot++;
                if (rsp_vld[1] !== 1'b0) $display("FAIL b2b_idle k=%0d: got vld=%b want 0", k, rsp_vld[1]);
                else npass++;
            end
            if (k == 5) begin
                ntot++;
                if (out_cnt[0] !== 3'd1 || out_cnt[1] !== 3'd3)
                    $display("FAIL b2b_cnt: got %0d/%0d want 1/3", out_cnt[0], out_cnt[1]);
                else npass++;
            end
        end
        rsp_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        int   nacc;
        logic hit;
        nacc = 0;
        rsp_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drv(1'b1, 1'b0, 13'(13'h100 + nacc), 8'h00, 8'h00, 6'(10 + nacc));
            hit = req_rdy[0];
            cyc();
            if (hit) nacc++;
        end
        ntot++;
        if (nacc !== 4) $display("FAIL bp_accepts: got %0d want 4", nacc);
        else npass++;
        ntot++;
        if (out_cnt[0] !== 3'd4 || out_cnt[1] !== 3'd4 || req_rdy[0] !== 1'b0 || req_rdy[1] !== 1'b0)
            $display("FAIL bp_full: got cnt=%0d/%0d rdy=%b/%b want 4/4 0/0",
                     out_cnt[0], out_cnt[1], req_rdy[0], req_rdy[1]);
        else npass++;
        rsp_rdy = 1'b1;
        cyc();
        ntot++;
        if (req_rdy[0] !== 1'b1 || out_cnt[0] !== 3'd3 || rsp_rid[0] !== 6'd11 || rsp_rid[1] !== 6'd11)
            $display("FAIL bp_first_pop: got rdy=%b cnt=%0d rid=%0d/%0d want 1 3 11/11",
                     req_rdy[0], out_cnt[0], rsp_rid[0], rsp_rid[1]);
        else npass++;
        cyc();
        idle();
        ntot++;
        if (out_cnt[0] !== 3'd3 || out_cnt[1] !== 3'd3)
            $display("FAIL bp_fifth: got cnt=%0d/%0d want 3/3", out_cnt[0], out_cnt[1]);
        else npass++;
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++) begin
                ntot++;
                if (rsp_vld[d] !== m_vld(d, ecnt) ||
                    (m_vld(d, ecnt) && (rsp_rid[d] !== mq[d][0].rid || rsp_rdt[d] !== mq[d][0].rdt)))
                    $display("FAIL bp_drain[%0d] k=%0d: got vld=%b rid=%0d want vld=%b",
                             d, k, rsp_vld[d], rsp_rid[d], m_vld(d, ecnt));
                else npass++;
            end
            cyc();
        end
        ntot++;
        if (out_cnt[0] !== 3'd0 || out_cnt[1] !== 3'd0)
            $display("FAIL bp_empty: got cnt=%0d/%0d want 0/0", out_cnt[0], out_cnt[1]);
        else npass++;
        rsp_rdy = 1'b0;
    endtask

    task automatic test_reset_inflight();
        rsp_rdy = 1'b0;
        drv(1'b1, 1'b0, 13'h010, 8'h00, 8'h00, 6'd20);
        cyc();
        drv(1'b1, 1'b0, 13'h010, 8'h00, 8'h00, 6'd21);
        cyc();
        rst = 1'b1;
        drv(1'b1, 1'b1, 13'h010, 8'h00, 8'hFF, 6'd0);
        cyc();
        rst = 1'b0;
        idle();
        ntot++;
        if (out_cnt[0] !== 3'd0 || out_cnt[1] !== 3'd0)
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", out_cnt[0], out_cnt[1]);
        else npass++;
        for (int k = 0; k < 4; k++) begin
            ntot++;
            if (rsp_vld[0] !== 1'b0 || rsp_vld[1] !== 1'b0)
                $display("FAIL rst_quiet k=%0d: got vld=%b/%b want 0/0", k, rsp_vld[0], rsp_vld[1]);
            else npass++;
            cyc();
        end
        drv(1'b1, 1'b0, 13'h010, 8'h00, 8'h00, 6'd22);
        cyc();
        idle();
        ntot++;
        if (rsp_vld[0] !== 1'b1 || rsp_rdt[0] !== 8'hA5 || rsp_rid[0] !== 6'd22)
            $display("FAIL rst_keep_lat1: got vld=%b rdt=%h rid=%0d want 1 a5 22",
                     rsp_vld[0], rsp_rdt[0], rsp_rid[0]);
        else npass++;
        cyc();
        cyc();
        ntot++;
        if (rsp_vld[1] !== 1'b1 || rsp_rdt[1] !== 8'hA5 || rsp_rid[1] !== 6'd22)
            $display("FAIL rst_keep_lat3: got vld=%b rdt=%h rid=%0d want 1 a5 22",
                     rsp_vld[1], rsp_rdt[1], rsp_rid[1]);
        else npass++;
        rsp_rdy = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        rsp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 1'b1, 13'(13'h200 + i), 8'($urandom), 8'hFF, 6'd0);
            cyc();
        end
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                ntot++;
                if (rsp_vld[d] !== m_vld(d, ecnt) ||
                    (m_vld(d, ecnt) && (rsp_rid[d] !== mq[d][0].rid || rsp_rdt[d] !== mq[d][0].rdt)))
                    $display("FAIL rnd_rsp[%0d] k=%0d: got vld=%b rid=%0d rdt=%h want vld=%b",
                             d, k, rsp_vld[d], rsp_rid[d], rsp_rdt[d], m_vld(d, ecnt));
                else npass++;
                ntot++;
                if (out_cnt[d] !== 3'(mq[d].size()) || req_rdy[d] !== (mq[d].size() < QD))
                    $display("FAIL rnd_cnt[%0d] k=%0d: got cnt=%0d rdy=%b want %0d",
                             d, k, out_cnt[d], req_rdy[d], mq[d].size());
                else npass++;
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            if (mq[0].size() < QD && mq[1].size() < QD && $urandom_range(0, 3) != 0)
                drv(1'b1, ($urandom_range(0, 2) == 0), 13'(13'h200 + $urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), 6'($urandom));
            else
                idle();
            cyc();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        rsp_rdy = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_masked();
        test_raw();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
